// File: rtl/v_issue_pkg.sv
// rtl/v_issue_pkg.sv - shared opcodes, entry type and vector-instruction decode helper
package v_issue_pkg;

    localparam logic [6:0] OPC_OP_V    = 7'b1010111;
    localparam logic [6:0] OPC_V_LOAD  = 7'b0000111;
    localparam logic [6:0] OPC_V_STORE = 7'b0100111;

    // Width codes 000/101/110/111 mark the vector forms of LOAD-FP/STORE-FP;
    // the remaining codes belong to scalar FP loads/stores and must not be queued.
    localparam logic [2:0] VMEM_W_8  = 3'b000;
    localparam logic [2:0] VMEM_W_16 = 3'b101;
    localparam logic [2:0] VMEM_W_32 = 3'b110;
    localparam logic [2:0] VMEM_W_64 = 3'b111;

    localparam int ISSUE_INSTR_W = 32;
    localparam int ISSUE_DATA_W  = 32;

    typedef struct packed {
        logic [ISSUE_INSTR_W-1:0] instr;
        logic [ISSUE_DATA_W-1:0]  rs1;
        logic [ISSUE_DATA_W-1:0]  rs2;
        logic                     is_ld;
        logic                     is_st;
    } issue_entry_t;

    function automatic logic is_vmem_width(input logic [2:0] width);
        return (width == VMEM_W_8) || (width == VMEM_W_16) ||
               (width == VMEM_W_32) || (width == VMEM_W_64);
    endfunction

    function automatic logic is_vector_instr(input logic [6:0] opcode, input logic [2:0] width);
        return (opcode == OPC_OP_V) ||
               (((opcode == OPC_V_LOAD) || (opcode == OPC_V_STORE)) && is_vmem_width(width));
    endfunction

endpackage

// File: rtl/v_issue_fifo_if.sv
// rtl/v_issue_fifo_if.sv - scalar-to-vector issue queue signal bundle
interface v_issue_fifo_if #(
    parameter int INSTR_W = 32,
    parameter int DATA_W  = 32
);
    logic [INSTR_W-1:0] s_instr_i;
    logic [DATA_W-1:0]  s_rs1_i;
    logic [DATA_W-1:0]  s_rs2_i;
    logic               s_stall_o;
    logic [INSTR_W-1:0] v_instr_o;
    logic [DATA_W-1:0]  v_rs1_o;
    logic [DATA_W-1:0]  v_rs2_o;
    logic               v_stall_i;
    logic               v_loads_pending_o;
    logic               v_stores_pending_o;

    // Core side: scalar core issues, vector core consumes.
    modport master (
        output s_instr_i, s_rs1_i, s_rs2_i, v_stall_i,
        input  s_stall_o, v_instr_o, v_rs1_o, v_rs2_o, v_loads_pending_o, v_stores_pending_o
    );

    // Queue side.
    modport slave (
        input  s_instr_i, s_rs1_i, s_rs2_i, v_stall_i,
        output s_stall_o, v_instr_o, v_rs1_o, v_rs2_o, v_loads_pending_o, v_stores_pending_o
    );
endinterface

// File: rtl/v_instr_classify.sv
// rtl/v_instr_classify.sv - combinational decode of vector / vector-load / vector-store
module v_instr_classify
    import v_issue_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] width,
    output logic       is_v,
    output logic       is_ld,
    output logic       is_st
);

    // Loads and stores are only flagged when the width code marks them as vector ops.
    always_comb begin
        is_v  = is_vector_instr(opcode, width);
        is_ld = is_v && (opcode == OPC_V_LOAD);
        is_st = is_v && (opcode == OPC_V_STORE);
    end

endmodule

// File: rtl/v_issue_fifo.sv
// rtl/v_issue_fifo.sv - in-order vector issue queue between scalar and vector cores
module v_issue_fifo
    import v_issue_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int INSTR_W = ISSUE_INSTR_W,
    parameter int DATA_W  = ISSUE_DATA_W
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   ce,
    v_issue_fifo_if.slave          bus,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    issue_entry_t       mem [DEPTH];
    issue_entry_t       wr_entry;
    issue_entry_t       head;
    logic [INSTR_W-1:0] head_instr;
    logic [DATA_W-1:0]  head_rs1;
    logic [DATA_W-1:0]  head_rs2;

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] ld_cnt;
    logic [CW-1:0] st_cnt;

    logic is_v;
    logic is_ld;
    logic is_st;
    logic full;
    logic empty;
    logic push;
    logic pop;

    v_instr_classify u_classify (
        .opcode (bus.s_instr_i[6:0]),
        .width  (bus.s_instr_i[14:12]),
        .is_v   (is_v),
        .is_ld  (is_ld),
        .is_st  (is_st)
    );

    // Handshake decisions; full uses the registered count, so a pop never frees a slot for the same cycle.
    always_comb begin
        full  = (count == CNT_FULL);
        empty = (count == '0);
        push  = ce && is_v && !full;
        pop   = ce && !empty && !bus.v_stall_i;
    end

    // Assemble the entry to be written from the scalar core's issue port.
    always_comb begin
        wr_entry.instr = bus.s_instr_i;
        wr_entry.rs1   = bus.s_rs1_i;
        wr_entry.rs2   = bus.s_rs2_i;
        wr_entry.is_ld = is_ld;
        wr_entry.is_st = is_st;
    end

    // Entry storage; contents are qualified by count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    // Pointers and occupancy; simultaneous push and pop keeps count while both pointers step.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Outstanding vector load/store counters feeding the scalar memory fence.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else begin
            case ({push && is_ld, pop && head.is_ld})
                2'b10:   ld_cnt <= ld_cnt + CNT_ONE;
                2'b01:   ld_cnt <= ld_cnt - CNT_ONE;
                default: ld_cnt <= ld_cnt;
            endcase
            case ({push && is_st, pop && head.is_st})
                2'b10:   st_cnt <= st_cnt + CNT_ONE;
                2'b01:   st_cnt <= st_cnt - CNT_ONE;
                default: st_cnt <= st_cnt;
            endcase
        end
    end

    // Head presentation; an empty queue shows the all-zero bubble the vector core ignores.
    always_comb begin
        head       = mem[rd_ptr];
        head_instr = empty ? '0 : head.instr;
        head_rs1   = empty ? '0 : head.rs1;
        head_rs2   = empty ? '0 : head.rs2;
    end

    // Outputs; s_stall_o deliberately ignores v_stall_i to avoid a combinational path between the cores.
    always_comb begin
        bus.v_instr_o          = head_instr;
        bus.v_rs1_o            = head_rs1;
        bus.v_rs2_o            = head_rs2;
        bus.s_stall_o          = full && is_v;
        bus.v_loads_pending_o  = (ld_cnt != '0);
        bus.v_stores_pending_o = (st_cnt != '0);
        count_o                = count;
    end

endmodule

// File: tb/tb_v_issue_fifo.sv
// tb/tb_v_issue_fifo.sv - directed vector-table bench for the vector issue queue
module tb_v_issue_fifo;

    localparam int DEPTH = 4;
    localparam int IW    = 32;
    localparam int DW    = 32;
    localparam int NVEC  = 28;

    localparam logic [31:0] ADDI  = 32'h0000_0013;
    localparam logic [31:0] FLW   = 32'h0000_2007;
    localparam logic [31:0] VLD   = 32'h0200_6007;
    localparam logic [31:0] VST   = 32'h0200_6027;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ce;
    logic [2:0] count_o;

    int checks = 0;
    int errors = 0;

    v_issue_fifo_if #(.INSTR_W(IW), .DATA_W(DW)) bus ();

    v_issue_fifo #(.DEPTH(DEPTH), .INSTR_W(IW), .DATA_W(DW)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .ce      (ce),
        .bus     (bus.slave),
        .count_o (count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ce;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        vst;
        logic [2:0]  e_cnt;
        logic [31:0] e_instr;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_sst;
        logic        e_ld;
        logic        e_st;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic logic [31:0] vi(input int i);
        return 32'h0220_A057 | (32'(i) << 7);
    endfunction

    function automatic logic [31:0] r1(input int i);
        return 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] r2(input int i);
        return 32'(i) * 32'h20;
    endfunction

    function automatic vec_t mk(input logic c, input logic [31:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input logic vs, input logic [2:0] ec,
                                input logic [31:0] ei, input logic [31:0] ea, input logic [31:0] eb,
                                input logic es, input logic el, input logic et);
        vec_t v;
        v.ce = c; v.instr = ins; v.rs1 = a; v.rs2 = b; v.vst = vs;
        v.e_cnt = ec; v.e_instr = ei; v.e_rs1 = ea; v.e_rs2 = eb;
        v.e_sst = es; v.e_ld = el; v.e_st = et;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic c, input logic [31:0] ins, input logic [31:0] a,
                         input logic [31:0] b, input logic vs);
        ce            = c;
        bus.s_instr_i = ins;
        bus.s_rs1_i   = a;
        bus.s_rs2_i   = b;
        bus.v_stall_i = vs;
    endtask

    logic [31:0] mq_i[$];
    logic [31:0] mq_a[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // idle / single issue
        tbl[0]  = mk(1, ADDI,  0,     0,     0, 0, 0,     0,     0,     0, 0, 0);
        tbl[1]  = mk(1, 0,     0,     0,     0, 0, 0,     0,     0,     0, 0, 0);
        tbl[2]  = mk(1, vi(1), r1(1), r2(1), 0, 0, 0,     0,     0,     0, 0, 0);
        tbl[3]  = mk(1, ADDI,  0,     0,     0, 1, vi(1), r1(1), r2(1), 0, 0, 0);
        tbl[4]  = mk(1, ADDI,  0,     0,     0, 0, 0,     0,     0,     0, 0, 0);
        // fill with stalled vector core, then back-pressure
        tbl[5]  = mk(1, vi(2), r1(2), r2(2), 1, 0, 0,     0,     0,     0, 0, 0);
        tbl[6]  = mk(1, vi(3), r1(3), r2(3), 1, 1, vi(2), r1(2), r2(2), 0, 0, 0);
        tbl[7]  = mk(1, vi(4), r1(4), r2(4), 1, 2, vi(2), r1(2), r2(2), 0, 0, 0);
        tbl[8]  = mk(1, vi(5), r1(5), r2(5), 1, 3, vi(2), r1(2), r2(2), 0, 0, 0);
        tbl[9]  = mk(1, vi(6), r1(6), r2(6), 1, 4, vi(2), r1(2), r2(2), 1, 0, 0);
        tbl[10] = mk(1, vi(6), r1(6), r2(6), 0, 4, vi(2), r1(2), r2(2), 1, 0, 0);
        tbl[11] = mk(1, vi(6), r1(6), r2(6), 0, 3, vi(3), r1(3), r2(3), 0, 0, 0);
        tbl[12] = mk(1, ADDI,  0,     0,     0, 3, vi(4), r1(4), r2(4), 0, 0, 0);
        tbl[13] = mk(1, ADDI,  0,     0,     0, 2, vi(5), r1(5), r2(5), 0, 0, 0);
        tbl[14] = mk(1, ADDI,  0,     0,     0, 1, vi(6), r1(6), r2(6), 0, 0, 0);
        tbl[15] = mk(1, ADDI,  0,     0,     0, 0, 0,     0,     0,     0, 0, 0);
        // pending flags
        tbl[16] = mk(1, VLD,   32'h30, 32'h31, 1, 0, 0,   0,      0,      0, 0, 0);
        tbl[17] = mk(1, VST,   32'h40, 32'h41, 1, 1, VLD, 32'h30, 32'h31, 0, 1, 0);
        tbl[18] = mk(1, ADDI,  0,     0,     1, 2, VLD,   32'h30, 32'h31, 0, 1, 1);
        tbl[19] = mk(1, ADDI,  0,     0,     0, 2, VLD,   32'h30, 32'h31, 0, 1, 1);
        tbl[20] = mk(1, ADDI,  0,     0,     0, 1, VST,   32'h40, 32'h41, 0, 0, 1);
        tbl[21] = mk(1, FLW,   0,     0,     0, 0, 0,     0,     0,     0, 0, 0);
        tbl[22] = mk(1, ADDI,  0,     0,     0, 0, 0,     0,     0,     0, 0, 0);
        // clock enable
        tbl[23] = mk(0, vi(7), r1(7), r2(7), 0, 0, 0,     0,     0,     0, 0, 0);
        tbl[24] = mk(1, vi(7), r1(7), r2(7), 0, 0, 0,     0,     0,     0, 0, 0);
        tbl[25] = mk(0, ADDI,  0,     0,     0, 1, vi(7), r1(7), r2(7), 0, 0, 0);
        tbl[26] = mk(1, ADDI,  0,     0,     0, 1, vi(7), r1(7), r2(7), 0, 0, 0);
        tbl[27] = mk(1, ADDI,  0,     0,     0, 0, 0,     0,     0,     0, 0, 0);

        rstn = 1'b0;
        drive(1, ADDI, 0, 0, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(tbl[i].ce, tbl[i].instr, tbl[i].rs1, tbl[i].rs2, tbl[i].vst);
            #1;
            chk($sformatf("v%0d count", i), 32'(count_o), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d v_instr", i), bus.v_instr_o, tbl[i].e_instr);
            chk($sformatf("v%0d v_rs1", i), bus.v_rs1_o, tbl[i].e_rs1);
            chk($sformatf("v%0d v_rs2", i), bus.v_rs2_o, tbl[i].e_rs2);
            chk($sformatf("v%0d s_stall", i), 32'(bus.s_stall_o), 32'(tbl[i].e_sst));
            chk($sformatf("v%0d ld_pend", i), 32'(bus.v_loads_pending_o), 32'(tbl[i].e_ld));
            chk($sformatf("v%0d st_pend", i), 32'(bus.v_stores_pending_o), 32'(tbl[i].e_st));
        end

        // wrap-around: 10 pushes against an alternating vector-core stall, checked against a queue model
        begin
            int  k;
            int  cyc;
            logic vs;
            logic mfull;
            k   = 0;
            cyc = 0;
            while ((k < 10 || mq_i.size() > 0) && cyc < 60) begin
                @(negedge clk);
                vs = (cyc % 2) == 1;
                if (k < 10) drive(1, vi(16 + k), r1(16 + k), r2(16 + k), vs);
                else        drive(1, ADDI, 0, 0, vs);
                #1;
                mfull = (mq_i.size() == DEPTH);
                chk($sformatf("wrap%0d count", cyc), 32'(count_o), 32'(mq_i.size()));
                chk($sformatf("wrap%0d s_stall", cyc), 32'(bus.s_stall_o), 32'((k < 10) && mfull));
                if (mq_i.size() > 0) begin
                    chk($sformatf("wrap%0d v_instr", cyc), bus.v_instr_o, mq_i[0]);
                    chk($sformatf("wrap%0d v_rs1", cyc), bus.v_rs1_o, mq_a[0]);
                end else begin
                    chk($sformatf("wrap%0d v_instr", cyc), bus.v_instr_o, 32'h0);
                end
                if (mq_i.size() > 0 && !vs) begin
                    void'(mq_i.pop_front());
                    void'(mq_a.pop_front());
                end
                if (k < 10 && !mfull) begin
                    mq_i.push_back(vi(16 + k));
                    mq_a.push_back(r1(16 + k));
                    k++;
                end
                cyc++;
            end
            checks++;
            if (k < 10 || mq_i.size() != 0) begin
                errors++;
                $display("FAIL wrap timeout: pushed %0d of 10, model left %0d", k, mq_i.size());
            end
        end

        // async reset with three entries queued
        @(negedge clk); drive(1, VLD,   32'h50, 32'h51, 1);
        @(negedge clk); drive(1, vi(8), r1(8),  r2(8),  1);
        @(negedge clk); drive(1, VST,   32'h60, 32'h61, 1);
        @(negedge clk); drive(1, vi(9), r1(9),  r2(9),  1);
        #1;
        chk("pre_rst count", 32'(count_o), 32'd3);
        chk("pre_rst v_instr", bus.v_instr_o, VLD);
        chk("pre_rst ld_pend", 32'(bus.v_loads_pending_o), 32'd1);
        chk("pre_rst st_pend", 32'(bus.v_stores_pending_o), 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("rst count", 32'(count_o), 32'd0);
        chk("rst v_instr", bus.v_instr_o, 32'h0);
        chk("rst v_rs1", bus.v_rs1_o, 32'h0);
        chk("rst s_stall", 32'(bus.s_stall_o), 32'd0);
        chk("rst ld_pend", 32'(bus.v_loads_pending_o), 32'd0);
        chk("rst st_pend", 32'(bus.v_stores_pending_o), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        drive(1, ADDI, 0, 0, 0);
        #1;
        chk("post_rst count", 32'(count_o), 32'd0);
        chk("post_rst v_instr", bus.v_instr_o, 32'h0);
        @(negedge clk); drive(1, vi(10), r1(10), r2(10), 0);
        @(negedge clk); drive(1, ADDI, 0, 0, 0);
        #1;
        chk("post_rst push count", 32'(count_o), 32'd1);
        chk("post_rst push v_instr", bus.v_instr_o, vi(10));
        @(negedge clk);
        #1;
        chk("post_rst drain count", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
